// File: rtl/mmu_tlb_mutex_arb.sv
// ---------------------------------------------------------------------------
// mmu_tlb_mutex_arb
//   N-requester ownership arbiter for the shared TLB lookup port of a vFPGA
//   MMU. Requesters (rd/wr/extra tlb_fsm channels) raise a level lock_req.
//   At most one of them owns the TLB at any time. Ownership is granted
//   round-robin, and the owner's lookup request is muxed onto the shared port.
//   A hold watchdog forcibly releases an owner that keeps the TLB too long, and
//   a saturating counter records how many cycles had a blocked request.
//
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   lock_req[N]     level ownership request per requester
//   unlock[N]       1-cycle release pulse per requester (only the owner's counts)
//   grant[N]        one-hot ownership, zero when free
//   owner_valid     TLB currently owned
//   owner_id        index of the owner (meaningful only when owner_valid=1)
//   s_addr/s_pid/s_strm/s_wr/s_valid
//                   per-requester lookup, requester i packed at slice i
//   m_addr/m_pid/m_strm/m_wr/m_valid
//                   owner's lookup toward the TLB controllers
//   timeout_valid   1-cycle pulse on a watchdog release
//   timeout_id      requester that was forcibly released
//   contend_cnt     saturating count of cycles with a blocked lock_req
// ---------------------------------------------------------------------------
module mmu_tlb_mutex_arb #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned ADDR_BITS = 48,
    parameter int unsigned PID_BITS  = 6,
    parameter int unsigned MAX_HOLD  = 1024,
    parameter int unsigned HCNT_BITS = 16,
    localparam int unsigned ID_BITS  = $clog2(N_REQ)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_REQ-1:0]           lock_req,
    input  logic [N_REQ-1:0]           unlock,
    output logic [N_REQ-1:0]           grant,
    output logic                       owner_valid,
    output logic [ID_BITS-1:0]         owner_id,
    input  logic [N_REQ*ADDR_BITS-1:0] s_addr,
    input  logic [N_REQ*PID_BITS-1:0]  s_pid,
    input  logic [N_REQ-1:0]           s_strm,
    input  logic [N_REQ-1:0]           s_wr,
    input  logic [N_REQ-1:0]           s_valid,
    output logic [ADDR_BITS-1:0]       m_addr,
    output logic [PID_BITS-1:0]        m_pid,
    output logic                       m_strm,
    output logic                       m_wr,
    output logic                       m_valid,
    output logic                       timeout_valid,
    output logic [ID_BITS-1:0]         timeout_id,
    output logic [31:0]                contend_cnt
);

    typedef enum logic {
        ST_FREE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [HCNT_BITS-1:0] HOLD_LAST =
        HCNT_BITS'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    // Registered state
    state_t                 r_state;
    logic [ID_BITS-1:0]     r_owner_id;
    logic [ID_BITS-1:0]     r_rr;
    logic [HCNT_BITS-1:0]   r_hcnt;
    logic                   r_tov;
    logic [ID_BITS-1:0]     r_tid;
    logic [31:0]            r_contend;

    // Next-state values
    state_t                 w_state_nxt;
    logic [ID_BITS-1:0]     w_owner_nxt;
    logic [ID_BITS-1:0]     w_rr_nxt;
    logic [HCNT_BITS-1:0]   w_hcnt_nxt;
    logic                   w_tov_nxt;
    logic [ID_BITS-1:0]     w_tid_nxt;
    logic [31:0]            w_contend_nxt;

    // Round-robin scan
    logic [N_REQ-1:0]       w_owner_oh;
    logic [N_REQ-1:0]       w_scan_req;
    logic [ID_BITS-1:0]     w_scan_base;
    logic [ID_BITS-1:0]     w_scan_idx;
    logic                   w_scan_found;
    logic [ID_BITS-1:0]     w_scan_sel;

    logic                   w_own_unlock;
    logic                   w_expire;
    logic                   w_blocked;
    logic [ID_BITS-1:0]     w_mux_idx;

    assign w_owner_oh = N_REQ'(1) << r_owner_id;

    // While owned, the scan starts after the owner (rr tracks the owner) and
    // the owner's own request is masked so it can never re-win a handover.
    always_comb begin
        w_scan_base = r_rr;
        w_scan_req  = lock_req;
        if (r_state == ST_OWNED) begin
            w_scan_base = r_owner_id;
            w_scan_req  = lock_req & ~w_owner_oh;
        end
    end

    always_comb begin
        w_scan_found = 1'b0;
        w_scan_sel   = '0;
        w_scan_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_scan_idx = ID_BITS'((32'(w_scan_base) + k) % N_REQ);
            if (!w_scan_found && w_scan_req[w_scan_idx]) begin
                w_scan_found = 1'b1;
                w_scan_sel   = w_scan_idx;
            end
        end
    end

    assign w_own_unlock = (r_state == ST_OWNED) && unlock[r_owner_id];
    // A same-cycle unlock takes precedence over the watchdog.
    assign w_expire     = (MAX_HOLD != 0) && (r_state == ST_OWNED) &&
                          (r_hcnt == HOLD_LAST) && !w_own_unlock;
    assign w_blocked    = |(lock_req & ~grant);

    // ---------------- state register ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= ST_FREE;
            r_owner_id <= '0;
            r_rr       <= ID_BITS'(N_REQ - 1);
            r_hcnt     <= '0;
            r_tov      <= 1'b0;
            r_tid      <= '0;
            r_contend  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner_id <= w_owner_nxt;
            r_rr       <= w_rr_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_tov      <= w_tov_nxt;
            r_tid      <= w_tid_nxt;
            r_contend  <= w_contend_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner_id;
        w_rr_nxt      = r_rr;
        w_hcnt_nxt    = r_hcnt;
        w_tov_nxt     = 1'b0;
        w_tid_nxt     = r_tid;
        w_contend_nxt = r_contend;

        if (w_blocked && (r_contend != '1))
            w_contend_nxt = r_contend + 32'd1;

        unique case (r_state)
            ST_FREE: begin
                if (w_scan_found) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_scan_sel;
                    w_rr_nxt    = w_scan_sel;
                    w_hcnt_nxt  = '0;
                end
            end
            ST_OWNED: begin
                if (w_own_unlock || w_expire) begin
                    // Release, with direct handover when someone else waits.
                    if (w_scan_found) begin
                        w_owner_nxt = w_scan_sel;
                        w_rr_nxt    = w_scan_sel;
                        w_hcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_FREE;
                    end
                    if (w_expire) begin
                        w_tov_nxt = 1'b1;
                        w_tid_nxt = r_owner_id;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + HCNT_BITS'(1);
                end
            end
            default: w_state_nxt = ST_FREE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        owner_valid   = (r_state == ST_OWNED);
        grant         = owner_valid ? w_owner_oh : '0;
        owner_id      = r_owner_id;
        timeout_valid = r_tov;
        timeout_id    = r_tid;
        contend_cnt   = r_contend;

        // Requester 0 drives the lookup fields while free.
        w_mux_idx = owner_valid ? r_owner_id : '0;
        m_addr    = s_addr[ADDR_BITS-1:0];
        m_pid     = s_pid[PID_BITS-1:0];
        m_strm    = s_strm[0];
        m_wr      = s_wr[0];
        m_valid   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_mux_idx == ID_BITS'(i)) begin
                m_addr  = s_addr[i*ADDR_BITS +: ADDR_BITS];
                m_pid   = s_pid[i*PID_BITS +: PID_BITS];
                m_strm  = s_strm[i];
                m_wr    = s_wr[i];
                m_valid = owner_valid & s_valid[i];
            end
        end
    end

endmodule

// File: tb/tb_mmu_tlb_mutex_arb.sv
module tb_mmu_tlb_mutex_arb;

    localparam int NR = 4;
    localparam int AB = 48;
    localparam int PB = 6;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [NR-1:0]  lock_req, unlock, grant;
    logic           owner_valid;
    logic [1:0]     owner_id;
    logic [NR*AB-1:0] s_addr;
    logic [NR*PB-1:0] s_pid;
    logic [NR-1:0]  s_strm, s_wr, s_valid;
    logic [AB-1:0]  m_addr;
    logic [PB-1:0]  m_pid;
    logic           m_strm, m_wr, m_valid;
    logic           timeout_valid;
    logic [1:0]     timeout_id;
    logic [31:0]    contend_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 aclk = ~aclk;

    mmu_tlb_mutex_arb #(
        .N_REQ    (NR),
        .ADDR_BITS(AB),
        .PID_BITS (PB),
        .MAX_HOLD (8),
        .HCNT_BITS(16)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .lock_req     (lock_req),
        .unlock       (unlock),
        .grant        (grant),
        .owner_valid  (owner_valid),
        .owner_id     (owner_id),
        .s_addr       (s_addr),
        .s_pid        (s_pid),
        .s_strm       (s_strm),
        .s_wr         (s_wr),
        .s_valid      (s_valid),
        .m_addr       (m_addr),
        .m_pid        (m_pid),
        .m_strm       (m_strm),
        .m_wr         (m_wr),
        .m_valid      (m_valid),
        .timeout_valid(timeout_valid),
        .timeout_id   (timeout_id),
        .contend_cnt  (contend_cnt)
    );

    typedef struct {
        logic [3:0] lock;
        logic [3:0] unl;
        logic [3:0] sval;
        logic [3:0] grant;
        logic       tov;
        logic [1:0] tid;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [AB-1:0] addr_of(input int i);
        return {16'hA5A5, 8'(i), 24'h123456 ^ 24'(i * 3)};
    endfunction
    function automatic logic [PB-1:0] pid_of(input int i);
        return 6'(i * 7 + 3);
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input int vi, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, vi, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] lk, input logic [3:0] ul, input logic [3:0] sv,
                       input logic [3:0] gr, input logic tv, input logic [1:0] td);
        vec_t v;
        v.lock = lk; v.unl = ul; v.sval = sv; v.grant = gr; v.tov = tv; v.tid = td;
        vecs.push_back(v);
    endtask

    // Each vector: inputs driven for one cycle, expected outputs after that edge.
    task automatic fill_table();
        // single grant, non-owner unlock, owner lock ignored, handover, free
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 0);
        add(4'b0001, 4'b0010, 4'b1000, 4'b0001, 0, 0);
        add(4'b0011, 4'b0000, 4'b0001, 4'b0001, 0, 0);
        add(4'b0011, 4'b0001, 4'b1000, 4'b0010, 0, 0);
        add(4'b0001, 4'b0010, 4'b0011, 4'b0001, 0, 0);
        add(4'b0000, 4'b0001, 4'b1111, 4'b0000, 0, 0);
        add(4'b1100, 4'b0000, 4'b0100, 4'b0100, 0, 0);
        add(4'b1100, 4'b0100, 4'b0100, 4'b1000, 0, 0);
        add(4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 0);
        // all four requesting, owner unlocks on its third cycle: 0,1,2,3,0
        for (int o = 0; o < 4; o++) begin
            logic [3:0] g = 4'b0001 << o;
            logic [3:0] s = (o < 2) ? 4'b1111 : 4'b0000;
            if (o == 0) add(4'b1111, 4'b0000, s, g, 0, 0);
            add(4'b1111, 4'b0000, s, g, 0, 0);
            add(4'b1111, 4'b0000, s, g, 0, 0);
            add(4'b1111, g, s, (o == 3) ? 4'b0001 : g << 1, 0, 0);
        end
        add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0);
        // watchdog: owner 2 never unlocks, requester 3 waits
        add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        for (int k = 0; k < 7; k++) add(4'b1100, 4'b0000, 4'b0100, 4'b0100, 0, 0);
        add(4'b1100, 4'b0000, 4'b0000, 4'b1000, 1, 2);
        add(4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0);
        // owner 3 unlocks exactly when the hold counter is at its last value
        for (int k = 0; k < 6; k++) add(4'b1000, 4'b0000, 4'b1000, 4'b1000, 0, 0);
        add(4'b1001, 4'b1000, 4'b0000, 4'b0001, 0, 0);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    endtask

    initial begin
        logic [3:0]  prev_grant;
        logic [31:0] exp_cnt;
        int          oi, mi;
        logic        ov;

        aresetn  = 1'b0;
        lock_req = '0;
        unlock   = '0;
        s_valid  = '0;
        for (int i = 0; i < NR; i++) begin
            s_addr[i*AB +: AB] = addr_of(i);
            s_pid[i*PB +: PB]  = pid_of(i);
            s_strm[i]          = 1'(i % 2);
            s_wr[i]            = 1'(i / 2);
        end
        fill_table();

        repeat (3) @(negedge aclk);
        chk("rst_grant",  0, 64'(grant), 64'h0);
        chk("rst_ov",     0, 64'(owner_valid), 64'h0);
        chk("rst_oid",    0, 64'(owner_id), 64'h0);
        chk("rst_tov",    0, 64'(timeout_valid), 64'h0);
        chk("rst_tid",    0, 64'(timeout_id), 64'h0);
        chk("rst_cnt",    0, 64'(contend_cnt), 64'h0);
        chk("rst_mvalid", 0, 64'(m_valid), 64'h0);
        chk("rst_maddr",  0, 64'(m_addr), 64'(addr_of(0)));

        aresetn    = 1'b1;
        prev_grant = '0;
        exp_cnt    = '0;
        for (int vi = 0; vi < vecs.size(); vi++) begin
            if (|(vecs[vi].lock & ~prev_grant)) exp_cnt++;
            lock_req = vecs[vi].lock;
            unlock   = vecs[vi].unl;
            s_valid  = vecs[vi].sval;
            @(posedge aclk);
            #1;
            ov = |vecs[vi].grant;
            oi = idx_of(vecs[vi].grant);
            mi = ov ? oi : 0;
            chk("grant",  vi, 64'(grant), 64'(vecs[vi].grant));
            chk("ovalid", vi, 64'(owner_valid), 64'(ov));
            if (ov) chk("owner_id", vi, 64'(owner_id), 64'(oi));
            chk("m_addr", vi, 64'(m_addr), 64'(addr_of(mi)));
            chk("m_pid",  vi, 64'(m_pid), 64'(pid_of(mi)));
            chk("m_strm", vi, 64'(m_strm), 64'(mi % 2));
            chk("m_wr",   vi, 64'(m_wr), 64'(mi / 2));
            chk("m_valid", vi, 64'(m_valid), 64'(ov & vecs[vi].sval[mi]));
            chk("tov",    vi, 64'(timeout_valid), 64'(vecs[vi].tov));
            if (vecs[vi].tov) chk("tid", vi, 64'(timeout_id), 64'(vecs[vi].tid));
            chk("contend", vi, 64'(contend_cnt), 64'(exp_cnt));
            prev_grant = vecs[vi].grant;
            @(negedge aclk);
        end

        // Saturation: preload near the top with requester 0 and 1 contending.
        unlock   = '0;
        s_valid  = '0;
        lock_req = 4'b0011;
        force dut.r_contend = 32'hFFFF_FFFC;
        @(negedge aclk);
        release dut.r_contend;
        repeat (4) @(negedge aclk);
        chk("sat_cnt",   100, 64'(contend_cnt), 64'hFFFF_FFFF);
        @(negedge aclk);
        chk("sat_hold",  101, 64'(contend_cnt), 64'hFFFF_FFFF);
        chk("sat_grant", 101, 64'(grant), 64'b0010);

        // Reset while owned.
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mrst_grant", 102, 64'(grant), 64'h0);
        chk("mrst_ov",    102, 64'(owner_valid), 64'h0);
        chk("mrst_cnt",   102, 64'(contend_cnt), 64'h0);
        chk("mrst_tov",   102, 64'(timeout_valid), 64'h0);
        chk("mrst_tid",   102, 64'(timeout_id), 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_grant", 103, 64'(grant), 64'b0001);
        chk("post_oid",   103, 64'(owner_id), 64'h0);
        chk("post_cnt",   103, 64'(contend_cnt), 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
